// File: rtl/cpu0_uart_tx_responder.sv
// rtl/cpu0_uart_tx_responder.sv - cpu0 bus console transmitter (8N1 UART TX)
// Purpose: answers cpu0 data-bus accesses in a 16-byte window at BASE_ADDR and
//   turns DATA stores into a serial 8N1 stream: staging unpacker -> TX FIFO ->
//   bit-timed shifter. Registers: 0x0 DATA (wo), 0x4 STATUS, 0x8 DIVISOR.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   en, rw, m_size    bus access enable, 1=read/0=write, access size
//   abus, dbus_in     byte address, write data
//   dbus_out          read data, high-Z when this block is not responding
//   hit               abus lies inside the register window
//   txd               serial output, idles high
//   irq               TX-done interrupt (level)
module cpu0_uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h00080000,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] CLK_DIV_RESET = 16'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        hit,
  output logic        txd,
  output logic        irq
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic            en_q, en_d;
  logic [31:0]     stage_data_q, stage_data_d;
  logic [2:0]      stage_cnt_q, stage_cnt_d;
  logic            overflow_q, overflow_d;
  logic            irq_en_q, irq_en_d;
  logic [15:0]     div_q, div_d;
  tx_state_e       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     baud_cnt_q, baud_cnt_d;
  logic [15:0]     frame_div_q, frame_div_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];

  logic            fifo_empty, fifo_full, tx_busy, wr_commit, push, pop, baud_done;
  logic [15:0]     eff_div;
  logic [2:0]      stage_n;
  logic [31:0]     status_val, reg_val, rd_val;

  assign hit        = (abus[31:4] == BASE_ADDR[31:4]);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == DEPTH_C);
  assign tx_busy    = (stage_cnt_q != 3'd0) || (state_q != S_IDLE);
  assign irq        = irq_en_q && fifo_empty && !tx_busy;
  // en_q makes a multi-cycle write strobe commit only on its first edge.
  assign wr_commit  = en && !rw && hit && !en_q;
  assign eff_div    = (frame_div_q == 16'd0) ? 16'd1 : frame_div_q;
  assign baud_done  = (baud_cnt_q == eff_div - 16'd1);
  assign status_val = {20'h0, 4'(fifo_cnt_q), 3'b000, irq_en_q, overflow_q,
                       tx_busy, fifo_full, fifo_empty};

  // Number of bytes a DATA store stages: m_size+1, cut at the first 0x00 byte.
  always_comb begin
    logic stop;
    stop    = 1'b0;
    stage_n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && (i <= int'(m_size))) begin
        if (dbus_in[8*i +: 8] == 8'h00) stop = 1'b1;
        else stage_n = 3'(i + 1);
      end
    end
  end

  always_comb begin
    reg_val = 32'h0;
    case (abus[3:0])
      4'h4:    reg_val = status_val;
      4'h8:    reg_val = {16'h0, div_q};
      default: reg_val = 32'h0;
    endcase
    case (m_size)
      2'b00:   rd_val = {24'h0, reg_val[7:0]};
      2'b01:   rd_val = {16'h0, reg_val[15:0]};
      2'b10:   rd_val = {8'h0, reg_val[23:0]};
      default: rd_val = reg_val;
    endcase
  end

  assign dbus_out = (en && rw && hit) ? rd_val : 32'bz;

  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    en_d         = en;
    stage_data_d = stage_data_q;
    stage_cnt_d  = stage_cnt_q;
    overflow_d   = overflow_q;
    irq_en_d     = irq_en_q;
    div_d        = div_q;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    baud_cnt_d   = baud_cnt_q;
    frame_div_d  = frame_div_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = S_START;
      end
      S_START: if (baud_done) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
      S_DATA: if (baud_done) begin
        shift_d = {1'b0, shift_q[7:1]};
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
        else bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_STOP: if (baud_done) begin
        // Chain straight into the next start bit so frames have no idle gap.
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) baud_cnt_d = baud_done ? 16'd0 : baud_cnt_q + 16'd1;

    // Divisor is latched per frame so a DIVISOR write never stretches a frame.
    if (pop) begin
      shift_d     = fifo_mem_q[rd_ptr_q];
      frame_div_d = div_q;
      baud_cnt_d  = 16'd0;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end

    push = (stage_cnt_q != 3'd0) && (!fifo_full || pop);
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      stage_data_d = {8'h00, stage_data_q[31:8]};
      stage_cnt_d  = stage_cnt_q - 3'd1;
    end
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

    // A DATA load only happens with staging empty, so it never meets a push.
    if (wr_commit) begin
      case (abus[3:0])
        4'h0: begin
          if (stage_cnt_q != 3'd0) begin
            overflow_d = 1'b1;
          end else begin
            stage_data_d = dbus_in;
            stage_cnt_d  = stage_n;
          end
        end
        4'h4: begin
          if (dbus_in[3]) overflow_d = 1'b0;
          irq_en_d = dbus_in[4];
        end
        4'h8:    div_d = dbus_in[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= stage_data_q[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q         <= 1'b0;
      stage_data_q <= 32'h0;
      stage_cnt_q  <= 3'd0;
      overflow_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      div_q        <= CLK_DIV_RESET;
      state_q      <= S_IDLE;
      shift_q      <= 8'h0;
      bit_cnt_q    <= 3'd0;
      baud_cnt_q   <= 16'd0;
      frame_div_q  <= CLK_DIV_RESET;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      en_q         <= en_d;
      stage_data_q <= stage_data_d;
      stage_cnt_q  <= stage_cnt_d;
      overflow_q   <= overflow_d;
      irq_en_q     <= irq_en_d;
      div_q        <= div_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      baud_cnt_q   <= baud_cnt_d;
      frame_div_q  <= frame_div_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end
endmodule

// File: doc/cpu0_uart_tx_responder.md
Name: cpu0_uart_tx_responder

Overview:
- Memory-mapped console transmitter that answers cpu0 data-bus accesses (en/rw/m_size/abus/dbus) at the IO window, base 0x80000.
- Converts CPU stores into a serial 8N1 byte stream through a staging unpacker, a TX FIFO and a bit-timed shifter.
- Sits beside memory0 on the same bus; the two decode disjoint address ranges.

Parameters:
- BASE_ADDR, 32'h00080000, base of the 16-byte register window; bits [3:0] are zero.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- CLK_DIV_RESET, 16'd16, reset value of DIVISOR (clocks per serial bit).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- en  in  1  bus access enable from cpu0.
- rw  in  1  1 = read, 0 = write.
- m_size  in  2  00 BYTE, 01 INT16, 10 INT24, 11 INT32.
- abus  in  32  byte address.
- dbus_in  in  32  write data.
- dbus_out  out  32  read data; 32'hZZZZZZZZ when not responding.
- hit  out  1  combinational: abus[31:4] == BASE_ADDR[31:4].
- txd  out  1  serial output; idles high.
- irq  out  1  TX-done interrupt, level.

Behaviour:
- Registers at abus[3:0]:
  - 0x0 DATA: write only; reads return 0.
  - 0x4 STATUS:
    - bit0 fifo_empty, bit1 fifo_full, bit2 tx_busy (staging non-empty or shifter active).
    - bit3 overflow (sticky), bit4 irq_en, bits[11:8] fifo count; other bits 0.
    - Write: bit3=1 clears overflow; bit4 loads irq_en.
  - 0x8 DIVISOR: [15:0] read/write.
  - 0xC and other offsets: reads 0, writes ignored.
- Reads are combinational:
  - dbus_out = register value masked to m_size (BYTE [7:0], INT16 [15:0], INT24 [23:0], zero-extended) while en=1 && rw=1 && hit.
  - Otherwise dbus_out is Z.
  - Reads have no side effects.
- Writes commit at the rising edge where en=1 && rw=0 && hit && en_q=0.
  - en_q is en registered, so an access held for several cycles commits exactly once.
  - The bus must be stable across that edge.
- DATA write loads staging with N = m_size+1 bytes, order [7:0], [15:8], [23:16], [31:24].
  - A 0x00 byte terminates the sequence; it and all later bytes are discarded.
  - A first byte of 0x00 stages nothing.
- Unpacker pushes one staged byte per clock into the FIFO.
  - Push is allowed when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the unpacker stalls; no data is lost.
- DATA write while staging is non-empty: write dropped, overflow=1.
- Shifter FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE, or STOP -> START directly if the FIFO is non-empty.
  - IDLE: txd=1. When the FIFO is non-empty, pop at the next edge, latch the byte and divisor, enter START.
  - START: txd=0 for DIV clocks.
  - DATA: bits LSB first, DIV clocks each.
  - STOP: txd=1 for DIV clocks.
  - One frame = 10*DIV clocks; back-to-back frames have no idle gap.
- Divisor:
  - DIVISOR writes take effect at the next frame start; a frame in progress keeps its latched divisor.
  - DIV=0 behaves as 1.
- irq = irq_en && fifo_empty && !tx_busy; combinational from registers.
- Reset values: txd=1, irq=0, FIFO empty, staging empty, overflow=0, irq_en=0, DIVISOR=CLK_DIV_RESET, en_q=0, FSM IDLE.
- Reset mid-frame forces txd=1 immediately, without waiting for a clock edge.
- Counters: bit counter is 3 bits and wraps only via FSM exit. FIFO pointers wrap modulo FIFO_DEPTH; count saturates at FIFO_DEPTH by construction.

Test Plan:
- Reset, then INT32 read at 0x80004 and 0x80008 -> dbus_out 0x00000001 and 0x00000010; irq=0; txd=1.
- Write DIVISOR=4, then BYTE write 0x41 to 0x80000 -> txd sequence, 4 clocks per bit: 0,1,0,0,0,0,0,1,0,1; 40 clocks total; STATUS bit2 falls after stop.
- DIV=4, INT32 write 0x00434241 -> frames 'A','B','C' back-to-back (120 clocks), no fourth frame; STATUS count peaks at 2 or 3 and returns to 0.
- DIV=16, three INT32 writes of 0x44434241 spaced 4 clocks -> count reaches 8, fifo_full=1, unpacker stalls; a fourth DATA write while staging is busy sets STATUS bit3; writing 0x8 to STATUS clears it; all 12 bytes are eventually sent in order.
- INT32 read of 0x8000C -> 0. Read of 0x7FFFC -> hit=0, dbus_out=Z. en held high 3 cycles on a BYTE DATA write -> exactly one frame.
- Write STATUS 0x10, send one byte -> irq rises after stop bit. Assert reset mid-DATA-bit -> txd=1 and irq=0 at once; STATUS reads 0x00000001 afterwards.
